// File: rtl/subtrator_completo_struct_if.sv
`default_nettype none
// ============================================================================
//  Module   : subtrator_completo_struct_if
//  Brief    : Operand/result bundle for the one-bit full subtractor slice.
//  Revision : 1.0 - initial release
// ============================================================================
interface subtrator_completo_struct_if;
    logic a;
    logic b;
    logic borrow_in;
    logic diff;
    logic borrow_out;
    logic diff_q;
    logic borrow_q;

    // Driver side: supplies operands, observes results.
    modport master (
        output a,
        output b,
        output borrow_in,
        input  diff,
        input  borrow_out,
        input  diff_q,
        input  borrow_q
    );

    // Subtractor side.
    modport slave (
        input  a,
        input  b,
        input  borrow_in,
        output diff,
        output borrow_out,
        output diff_q,
        output borrow_q
    );
endinterface
`default_nettype wire

// File: rtl/subtrator_completo_struct.sv
`default_nettype none
// ============================================================================
//  Module   : subtrator_completo_struct
//  Brief    : Gate-level full subtractor (a - b - borrow_in) from two half
//             subtractors and an OR, plus a side register for bit-serial use.
//  Revision : 1.0 - initial release
// ============================================================================
module subtrator_completo_struct (
    input  wire                            clk,
    input  wire                            rst_n,
    subtrator_completo_struct_if.slave     bus
);

    wire w_a_n;
    wire w_d1;
    wire w_b1;
    wire w_d1_n;
    wire w_b2;
    wire w_diff;
    wire w_borrow_out;

    logic r_diff_q;
    logic r_borrow_q;

    // Half subtractor 1: a - b
    xor u_hs1_xor (w_d1, bus.a, bus.b);
    not u_hs1_not (w_a_n, bus.a);
    and u_hs1_and (w_b1, w_a_n, bus.b);

    // Half subtractor 2: d1 - borrow_in
    xor u_hs2_xor (w_diff, w_d1, bus.borrow_in);
    not u_hs2_not (w_d1_n, w_d1);
    and u_hs2_and (w_b2, w_d1_n, bus.borrow_in);

    or  u_borrow_or (w_borrow_out, w_b1, w_b2);

    assign bus.diff       = w_diff;
    assign bus.borrow_out = w_borrow_out;

    // The combinational path above is deliberately kept outside reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff_q   <= 1'b0;
            r_borrow_q <= 1'b0;
        end else begin
            r_diff_q   <= w_diff;
            r_borrow_q <= w_borrow_out;
        end
    end

    assign bus.diff_q   = r_diff_q;
    assign bus.borrow_q = r_borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_subtrator_completo_struct.sv
`default_nettype none
// ============================================================================
//  Module   : tb_subtrator_completo_struct
//  Brief    : Directed self-checking bench for the full subtractor slice.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_subtrator_completo_struct;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    subtrator_completo_struct_if bus ();

    subtrator_completo_struct dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic bi);
        bus.a         = a;
        bus.b         = b;
        bus.borrow_in = bi;
    endtask

    logic [2:0] vec;
    logic       exp_diff   [8];
    logic       exp_borrow [8];
    logic       ser_a      [4];
    logic       ser_b      [4];
    logic       ser_diff   [4];
    logic [3:0] result;

    initial begin
        total = 0;
        bad   = 0;
        // Hand-computed truth table, index = {a,b,borrow_in}
        exp_diff   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_borrow = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        // 0011 - 0101, LSB first
        ser_a      = '{1'b1, 1'b1, 1'b0, 1'b0};
        ser_b      = '{1'b1, 1'b0, 1'b1, 1'b0};
        ser_diff   = '{1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state and combinational path during reset
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        #2;
        check("rst_diff",     bus.diff,       1'b1);
        check("rst_borrow",   bus.borrow_out, 1'b1);
        check("rst_diff_q",   bus.diff_q,     1'b0);
        check("rst_borrow_q", bus.borrow_q,   1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_diff_q",   bus.diff_q,   1'b0);
        check("rst_hold_borrow_q", bus.borrow_q, 1'b0);

        // Exhaustive combinational sweep
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            drive(vec[2], vec[1], vec[0]);
            #1;
            check($sformatf("sweep_diff_%0d", i),   bus.diff,       exp_diff[i]);
            check($sformatf("sweep_borrow_%0d", i), bus.borrow_out, exp_borrow[i]);
            #9;
        end

        // Register latency: clear with 000, then load 100
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("lat_pre_diff_q", bus.diff_q, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0);
        #1;
        check("lat_before_edge_diff_q", bus.diff_q, 1'b0);
        @(posedge clk);
        #1;
        check("lat_after_diff_q",   bus.diff_q,   1'b1);
        check("lat_after_borrow_q", bus.borrow_q, 1'b0);

        // Asynchronous reset between edges
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("ar_loaded_borrow_q", bus.borrow_q, 1'b1);
        check("ar_loaded_diff_q",   bus.diff_q,   1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_borrow_q", bus.borrow_q,   1'b0);
        check("ar_diff_q",   bus.diff_q,     1'b0);
        check("ar_diff",     bus.diff,       1'b0);
        check("ar_borrow",   bus.borrow_out, 1'b1);

        // Bit-serial 4-bit subtract with borrow_q fed back
        @(negedge clk);
        rst_n = 1'b1;
        result = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            drive(ser_a[k], ser_b[k], bus.borrow_q);
            #1;
            check($sformatf("ser_diff_%0d", k), bus.diff, ser_diff[k]);
            @(posedge clk);
            #1;
            check($sformatf("ser_diff_q_%0d", k), bus.diff_q, ser_diff[k]);
            result[k] = bus.diff_q;
            @(negedge clk);
        end
        check("ser_final_borrow_q", bus.borrow_q, 1'b1);
        total++;
        if (result !== 4'b1110) begin
            bad++;
            $display("FAIL ser_result: got=%b expected=1110", result);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subtrator_completo_struct.md
# subtrator_completo_struct

One-bit full subtractor computing a − b − borrow_in and producing a difference bit and a borrow-out bit. It is the bit-slice building block for ripple-borrow multi-bit subtractors. The core is built structurally from two half subtractors plus an OR gate, with a combinational result path. A clocked side-register captures the result for bit-serial use.

## Interface
Parameters:
- None.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- a  input  1  minuend bit.
- b  input  1  subtrahend bit.
- borrow_in  input  1  borrow from the less-significant slice.
- diff  output  1  combinational difference, a ^ b ^ borrow_in.
- borrow_out  output  1  combinational borrow to the more-significant slice.
- diff_q  output  1  registered copy of diff.
- borrow_q  output  1  registered copy of borrow_out.

## Operation
- Structural decomposition, gate primitives only, no behavioural arithmetic:
  - Half subtractor 1: d1 = a ^ b, b1 = ~a & b.
  - Half subtractor 2: diff = d1 ^ borrow_in, b2 = ~d1 & borrow_in.
  - borrow_out = b1 | b2.
- Full truth table, listed as a b borrow_in -> diff borrow_out:
  - 000 -> 0 0
  - 001 -> 1 1
  - 010 -> 1 1
  - 011 -> 0 1
  - 100 -> 1 0
  - 101 -> 0 0
  - 110 -> 0 0
  - 111 -> 1 1
- diff and borrow_out depend only on a, b and borrow_in.
  - They are independent of clk and rst_n.
  - They remain valid during reset.
- Register stage, on each rising clk edge with rst_n high:
  - diff_q <= diff.
  - borrow_q <= borrow_out.
- Bit-serial use: external logic feeds borrow_q back to borrow_in. Each clock then processes one bit, LSB first.
- X/Z on any input propagates per standard gate semantics. No special handling is defined.

## Timing
- Combinational path a/b/borrow_in -> diff/borrow_out: zero cycles.
  - The path is purely gate-delay.
  - Outputs settle within the same time step as an input change, before any 10 ns stimulus interval ends.
- Registered outputs have 1-cycle latency: values present before edge N appear on diff_q/borrow_q after edge N.
- Reset:
  - rst_n low immediately forces diff_q = 0 and borrow_q = 0, without waiting for clk.
  - Both registers hold 0 while rst_n is low.
  - The first capture occurs on the first rising edge after rst_n returns high.
- Reset asserted mid-operation clears both registers at once. The combinational outputs are unaffected.
- An input change coincident with a clock edge: the register captures the value settled before the edge (standard setup semantics).

## Test plan
- Exhaustive combinational sweep:
  - Apply all 8 {a,b,borrow_in} combinations in order 000..111, holding each 10 ns.
  - Required diff/borrow_out: 0/0, 1/1, 1/1, 0/1, 1/0, 0/0, 0/0, 1/1.
- Reset independence of the combinational path:
  - Hold rst_n=0 with a=0, b=1, borrow_in=0.
  - Required: diff=1, borrow_out=1, diff_q=0, borrow_q=0.
- Asynchronous reset:
  - Register a=0, b=1, borrow_in=1 so that borrow_q=1, diff_q=0.
  - Drop rst_n between clock edges.
  - Required: borrow_q=0 immediately, with no clk edge.
- Register latency:
  - With rst_n=1, set a=1, b=0, borrow_in=0 before an edge.
  - Required: diff_q=1 and borrow_q=0 after that edge, not before.
- Bit-serial 4-bit subtract:
  - Feed borrow_q back to borrow_in and compute 0011 − 0101 LSB first.
  - Required serial diff bits (LSB first): 0,1,1,1, i.e. 1110.
  - Final borrow_q = 1, indicating a negative result.
